// File: rtl/ram_burst_master.sv
// ram_burst_master: burst master for a one-cycle-latency byte RAM. Define RAM_BURST_NOWRAP_EN to reject bursts that would wrap past address 127.
module ram_burst_master (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [6:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic [6:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_CAPTURE, RD_HOLD} state_t;
    state_t     state;
    logic [6:0] addr;
    logic [4:0] left;
    logic       bad;
`ifdef RAM_BURST_NOWRAP_EN
    assign bad = ({1'b0, cmd_addr} + {4'b0, cmd_len}) > 8'd127;
`else
    assign bad = 1'b0;
`endif
    // Burst sequencing; every output is a register so the RAM and handshake pins are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= 7'd0;
            left      <= 5'd0;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'd0;
            ram_addr  <= 7'd0;
            ram_we    <= 1'b0;
            ram_wdata <= 8'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready && bad) begin
                        err <= 1'b1;
                    end else if (cmd_valid && cmd_ready) begin
                        addr      <= cmd_addr;
                        ram_addr  <= cmd_addr;
                        left      <= {1'b0, cmd_len} + 5'd1;
                        cmd_ready <= 1'b0;
                        wr_ready  <= cmd_we;
                        busy      <= 1'b1;
                        state     <= cmd_we ? WRITE : RD_ISSUE;
                    end
                end
                WRITE: begin
                    if (wr_valid) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= wr_data;
                        addr      <= addr + 7'd1;
                        left      <= left - 5'd1;
                        if (left == 5'd1) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                RD_ISSUE: state <= RD_CAPTURE;
                RD_CAPTURE: begin
                    rd_data  <= ram_rdata;
                    rd_valid <= 1'b1;
                    state    <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        addr     <= addr + 7'd1;
                        left     <= left - 5'd1;
                        if (left == 5'd1) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state    <= RD_ISSUE;
                            ram_addr <= addr + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed bench with a RAM model and write/read scoreboards for ram_burst_master.
module tb_ram_burst_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [6:0] cmd_addr = 7'd0;
    logic [3:0] cmd_len = 4'd0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'd0;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [6:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  mem[128];

    ram_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (ram_we) begin
            checks++;
            assert (wq.size() > 0) else begin
                errors++;
                $error("FAIL wr_extra observed addr %0h data %0h expected no write", ram_addr, ram_wdata);
            end
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("wr_addr", ram_addr, e[15:8]);
                chk("wr_data", ram_wdata, e[7:0]);
            end
        end
        if (rd_valid && rd_ready) begin
            checks++;
            assert (rq.size() > 0) else begin
                errors++;
                $error("FAIL rd_extra observed %0h expected no read", rd_data);
            end
            if (rq.size() > 0) chk("rd_data", rd_data, rq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [6:0] a, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_addr = a;
        cmd_len = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rv(output int at);
        int n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_valid_timeout", rd_valid, 1);
        at = cyc;
    endtask

    initial begin
        int t;
        int prev;
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_ready", wr_ready, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 4; i++) wq.push_back({8'h10 + 8'(i), 8'hA1 + 8'(i)});
        issue(1'b1, 7'h10, 4'd3);
        chk("wr_busy", busy, 1);
        chk("wr_ready", wr_ready, 1);
        chk("wr_cmd_ready", cmd_ready, 0);
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'hA1 + 8'(i);
            tick();
            chk("wr_we_consec", ram_we, 1);
        end
        chk("wr_end_cmd_ready", cmd_ready, 1);
        chk("wr_end_busy", busy, 0);
        wr_valid = 1'b0;
        tick();
        chk("wr_end_we_low", ram_we, 0);

        wq.push_back({8'h20, 8'h55});
        wq.push_back({8'h21, 8'h66});
        issue(1'b1, 7'h20, 4'd1);
        wr_valid = 1'b1;
        wr_data = 8'h55;
        tick();
        chk("gap_we1", ram_we, 1);
        wr_valid = 1'b0;
        tick();
        chk("gap_idle1", ram_we, 0);
        tick();
        chk("gap_idle2", ram_we, 0);
        wr_valid = 1'b1;
        wr_data = 8'h66;
        tick();
        chk("gap_we2", ram_we, 1);
        wr_valid = 1'b0;
        tick();

        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) rq.push_back(8'hA1 + 8'(i));
        issue(1'b0, 7'h10, 4'd3);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_rv(t);
            if (i > 0) chk("rd_spacing", t - prev, 3);
            prev = t;
            tick();
        end
        chk("rd_end_cmd_ready", cmd_ready, 1);

        rd_ready = 1'b0;
        rq.push_back(8'hA3);
        rq.push_back(8'hA4);
        issue(1'b0, 7'h12, 4'd1);
        wait_rv(t);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", rd_valid, 1);
            chk("hold_data", rd_data, 8'hA3);
            chk("hold_addr", ram_addr, 7'h12);
        end
        rd_ready = 1'b1;
        tick();
        chk("hold_release", rd_valid, 0);
        chk("hold_next_addr", ram_addr, 7'h13);
        wait_rv(t);
        tick();
        chk("hold_end_cmd_ready", cmd_ready, 1);

`ifdef RAM_BURST_NOWRAP_EN
        issue(1'b1, 7'h7E, 4'd2);
        chk("nowrap_err", err, 1);
        chk("nowrap_busy", busy, 0);
        chk("nowrap_cmd_ready", cmd_ready, 1);
        wr_valid = 1'b1;
        tick();
        chk("nowrap_err_pulse", err, 0);
        chk("nowrap_we0", ram_we, 0);
        tick();
        chk("nowrap_we1", ram_we, 0);
        wr_valid = 1'b0;
`else
        wq.push_back({8'h7E, 8'h11});
        wq.push_back({8'h7F, 8'h22});
        wq.push_back({8'h00, 8'h33});
        issue(1'b1, 7'h7E, 4'd2);
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'h11 * 8'(i + 1);
            tick();
            chk("wrap_we", ram_we, 1);
        end
        chk("wrap_last_addr", ram_addr, 7'h00);
        chk("wrap_err", err, 0);
        wr_valid = 1'b0;
        tick();
`endif

        wq.push_back({8'h40, 8'h01});
        issue(1'b1, 7'h40, 4'd3);
        wr_valid = 1'b1;
        wr_data = 8'h01;
        tick();
        chk("rstmid_we1", ram_we, 1);
        wr_data = 8'h02;
        rst = 1'b1;
        tick();
        chk("rstmid_we", ram_we, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        tick();
        chk("rstmid_cmd_ready_rise", cmd_ready, 1);
        chk("rstmid_idle_we", ram_we, 0);
        tick();
        chk("idle_ignores_wr", ram_we, 0);
        wr_valid = 1'b0;
        tick();

        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the command ports:
- cmd_valid, input, 1 bit: command offered.
- cmd_ready, output, 1 bit: command accepted when cmd_valid is also high.
- cmd_we, input, 1 bit: 1 = write burst, 0 = read burst.
- cmd_addr, input, 7 bits: start address.
- cmd_len, input, 4 bits: beats minus 1, giving 1..16 beats.
REQ-004 SHALL have the write-data ports:
- wr_valid, input, 1 bit: write byte offered.
- wr_ready, output, 1 bit: write byte accepted.
- wr_data, input, 8 bits: write byte.
REQ-005 SHALL have the read-data ports:
- rd_valid, output, 1 bit: read byte available.
- rd_ready, input, 1 bit: consumer takes the byte.
- rd_data, output, 8 bits: read byte.
REQ-006 SHALL have the RAM-side ports, matching the DFFRAM ui_in/uo_out/uio_in mapping:
- ram_addr, output, 7 bits: RAM address.
- ram_we, output, 1 bit: RAM write enable.
- ram_wdata, output, 8 bits: RAM write byte.
- ram_rdata, input, 8 bits: RAM read byte.
REQ-007 SHALL have the status ports:
- busy, output, 1 bit: high in every state except IDLE.
- err, output, 1 bit: command-rejected pulse.

Function
REQ-008 SHALL implement the states IDLE, WRITE, RD_ISSUE, RD_CAPTURE and RD_HOLD.
REQ-009 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready it SHALL latch the address, the beat count (cmd_len+1) and the direction, then enter WRITE (cmd_we=1) or RD_ISSUE (cmd_we=0).
REQ-010 WRITE: SHALL drive wr_ready=1. Each wr_valid&&wr_ready at edge N SHALL produce, in cycle N+1, exactly one cycle of ram_we=1 with ram_addr=current address and ram_wdata=wr_data; the address then increments.
REQ-011 ram_we SHALL be 0 in every cycle that does not carry a write beat; gaps in wr_valid insert idle cycles and never repeat a write.
REQ-012 SHALL assume a RAM with one-cycle read latency: ram_rdata is valid one cycle after ram_addr is presented with ram_we=0.
REQ-013 RD_ISSUE: SHALL present ram_addr=current address with ram_we=0 for one cycle, then enter RD_CAPTURE.
REQ-014 RD_CAPTURE: SHALL register ram_rdata into rd_data, set rd_valid=1 and enter RD_HOLD.
REQ-015 RD_HOLD: SHALL hold rd_data and rd_valid stable until rd_ready=1.
REQ-016 On rd_valid&&rd_ready in RD_HOLD, rd_valid SHALL drop at that edge; the block then increments the address and enters RD_ISSUE if beats remain, otherwise IDLE.
REQ-017 Minimum read throughput SHALL be 1 byte per 3 cycles; minimum write throughput SHALL be 1 byte per cycle.
REQ-018 The address SHALL increment modulo 128 (7-bit), subject to REQ-023.
REQ-019 After the last write beat is accepted, the block SHALL return to IDLE at the same edge; cmd_ready SHALL be high in the following cycle while the final ram_we pulse completes.
REQ-020 cmd_valid SHALL be ignored outside IDLE; wr_valid SHALL be ignored outside WRITE; rd_ready SHALL be ignored outside RD_HOLD.

Reset
REQ-021 With rst=1 at an edge, the block SHALL enter IDLE and clear all outputs to 0: cmd_ready, wr_ready, rd_valid, rd_data, ram_addr, ram_we, ram_wdata, busy and err. cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-022 Reset mid-burst SHALL abandon the burst; ram_we SHALL be 0 in the cycle after the reset edge, and no partial beat SHALL be replayed.

Configuration
REQ-023 Macro RAM_BURST_NOWRAP_EN:
- When defined: a command with cmd_addr+cmd_len>127 SHALL be accepted (cmd_ready handshake), SHALL perform no RAM access, SHALL assert err=1 for exactly one cycle, and SHALL stay in IDLE.
- When undefined: bursts SHALL wrap 127->0 and err SHALL be tied to 0.

Verification
REQ-024 Write burst addr=0x10, len=3, data 0xA1,0xA2,0xA3,0xA4 with wr_valid held high SHALL produce ram_we pulses on 4 consecutive cycles at ram_addr 0x10..0x13.
REQ-025 Read burst addr=0x10, len=3, rd_ready=1, with a RAM model preloaded as in REQ-024, SHALL return rd_data 0xA1..0xA4, each rd_valid spaced 3 cycles apart.
REQ-026 Read with rd_ready held low for 5 cycles SHALL keep rd_valid=1 and rd_data stable, and SHALL issue no new ram_addr until rd_ready rises.
REQ-027 Write addr=0x7E, len=2:
- Without RAM_BURST_NOWRAP_EN: SHALL write addresses 0x7E, 0x7F, 0x00.
- With RAM_BURST_NOWRAP_EN: SHALL produce err=1 for one cycle and no ram_we.
REQ-028 Asserting rst during the 2nd beat of a 4-beat write SHALL give ram_we=0, busy=0 and cmd_ready=0 in the next cycle, and cmd_ready=1 in the cycle after rst deasserts.
